// File: rtl/sdram_dma_pkg.sv
// Shared types and default constants for the SDRAM DMA initiator.
package sdram_dma_pkg;

    localparam int unsigned ADDR_W        = 23;
    localparam int unsigned DATA_W        = 32;
    localparam int unsigned LEN_W         = 10;
    localparam int unsigned TIMEOUT_LIMIT = 255;
    localparam int unsigned TMO_W         = 8;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        GUARD,
        WAIT_RD,
        FIN
    } state_t;

endpackage

// File: rtl/sdram_dma_fifo.sv
// Synchronous read-return FIFO; flush empties it in a single cycle.
module sdram_dma_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = sdram_dma_pkg::DATA_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    push,
    input  logic [DATA_W-1:0]       push_data,
    input  logic                    pop,
    output logic [DATA_W-1:0]       pop_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[PTR_W'(i)] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sdram_dma_initiator.sv
// Single-channel DMA initiator issuing one-word requests to the SDRAM controller.
// Define SDRAM_DMA_TIMEOUT_EN to abort reads whose data never returns.
module sdram_dma_initiator #(
    parameter int unsigned ADDR_W     = sdram_dma_pkg::ADDR_W,
    parameter int unsigned DATA_W     = sdram_dma_pkg::DATA_W,
    parameter int unsigned LEN_W      = sdram_dma_pkg::LEN_W,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              dir,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              active,
    output logic              done,
    output logic              err,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W-1:0] user_addr,
    output logic              rw,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out,
    input  logic              busy,
    output logic              in_valid,
    input  logic              out_valid
);
    import sdram_dma_pkg::state_t;
    import sdram_dma_pkg::IDLE;
    import sdram_dma_pkg::ISSUE;
    import sdram_dma_pkg::GUARD;
    import sdram_dma_pkg::WAIT_RD;
    import sdram_dma_pkg::FIN;

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t            state;
    logic              dir_q;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  idx;
    logic              abort_q;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic              issue_c;
    logic              last_c;
    logic              timeout_hit;

    // Reads only issue while a FIFO slot is free for the returning word.
    assign issue_c   = (state == ISSUE) && !busy && (dir_q ? s_valid : !fifo_full);
    assign s_ready   = issue_c && dir_q;
    assign last_c    = (idx == len_q - LEN_W'(1));
    assign fifo_push = (state == WAIT_RD) && out_valid && !timeout_hit;
    assign fifo_pop  = !fifo_empty && m_ready;
    assign m_valid   = !fifo_empty;

`ifdef SDRAM_DMA_TIMEOUT_EN
    localparam int unsigned TMO_W = sdram_dma_pkg::TMO_W;
    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state != WAIT_RD || out_valid) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    assign timeout_hit = (state == WAIT_RD) && !out_valid &&
                         (tmo_cnt == TMO_W'(sdram_dma_pkg::TIMEOUT_LIMIT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    sdram_dma_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (timeout_hit),
        .push      (fifo_push),
        .push_data (data_out),
        .pop       (fifo_pop),
        .pop_data  (m_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Transfer sequencer; request strobes and status pulses default low each cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            dir_q     <= 1'b0;
            base_q    <= '0;
            len_q     <= '0;
            idx       <= '0;
            abort_q   <= 1'b0;
            active    <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            in_valid  <= 1'b0;
            rw        <= 1'b0;
            user_addr <= '0;
            data_in   <= '0;
        end else begin
            in_valid <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dir_q  <= dir;
                        base_q <= base_addr;
                        len_q  <= length;
                        idx    <= '0;
                        if (length == '0) begin
                            state <= FIN;
                        end else begin
                            state  <= ISSUE;
                            active <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (issue_c) begin
                        in_valid  <= 1'b1;
                        user_addr <= base_q + ADDR_W'(idx);
                        rw        <= dir_q;
                        if (dir_q) begin
                            data_in <= s_data;
                        end
                        state <= dir_q ? GUARD : WAIT_RD;
                    end
                end
                GUARD: begin
                    if (last_c) begin
                        state <= FIN;
                    end else begin
                        idx   <= idx + LEN_W'(1);
                        state <= ISSUE;
                    end
                end
                WAIT_RD: begin
                    if (timeout_hit) begin
                        abort_q <= 1'b1;
                        state   <= FIN;
                    end else if (out_valid) begin
                        if (last_c) begin
                            state <= FIN;
                        end else begin
                            idx   <= idx + LEN_W'(1);
                            state <= ISSUE;
                        end
                    end
                end
                FIN: begin
                    if (abort_q || fifo_count == '0) begin
                        done    <= 1'b1;
                        err     <= abort_q;
                        abort_q <= 1'b0;
                        active  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_dma_initiator.sv
// Scoreboard bench for sdram_dma_initiator with a behavioural SDRAM controller model.
module tb_sdram_dma_initiator;
    localparam int unsigned ADDR_W     = 23;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned LEN_W      = 10;
    localparam int unsigned FIFO_DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    logic start, dir;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  length;
    logic active, done, err;
    logic [DATA_W-1:0] s_data;
    logic s_valid, s_ready;
    logic [DATA_W-1:0] m_data;
    logic m_valid, m_ready;
    logic [ADDR_W-1:0] user_addr;
    logic rw;
    logic [DATA_W-1:0] data_in, data_out;
    logic busy, in_valid, out_valid;

    sdram_dma_initiator #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .dir(dir), .base_addr(base_addr),
        .length(length), .active(active), .done(done), .err(err),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .user_addr(user_addr), .rw(rw), .data_in(data_in), .data_out(data_out),
        .busy(busy), .in_valid(in_valid), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              rw;
        logic [DATA_W-1:0] data;
    } req_t;

    req_t              exp_req[$];
    logic [DATA_W-1:0] exp_rd[$];
    logic              exp_done[$];
    logic [DATA_W-1:0] src[$];

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    longint last_iv = -100;
    longint last_done = 0;
    int     n_issue = 0;
    int     src_idx = 0;
    int     rdy_mode = 1;
    int     ctl_cnt = 0;
    bit     hold_valid = 1'b1;
    bit     drop_reads = 1'b0;
    bit     busy_force = 1'b0;
    bit     busy_c = 1'b0;
    bit     ctl_rd = 1'b0;
    bit     hs_s = 1'b0;
    bit     busy_pre = 1'b0;
    bit     ov_prev = 1'b0;
    logic [ADDR_W-1:0] ctl_addr = '0;

    assign busy = busy_c | busy_force;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Controller model and stream endpoints: drive on negedge, sample just before posedge.
    initial begin : bfm
        out_valid = 1'b0;
        data_out  = '0;
        s_valid   = 1'b0;
        s_data    = '0;
        m_ready   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ctl_cnt   = 0;
                busy_c    = 1'b0;
                out_valid = 1'b0;
            end else begin
                if (ov_prev) chk("rd_to_mvalid", 64'(m_valid), 64'd1);
                out_valid = 1'b0;
                if (ctl_cnt > 0) begin
                    ctl_cnt--;
                    if (ctl_cnt == 0) begin
                        busy_c = 1'b0;
                        if (ctl_rd && !drop_reads) begin
                            out_valid = 1'b1;
                            data_out  = 32'h0000_00D0 + 32'(ctl_addr);
                        end
                    end
                end
                if (in_valid) begin
                    busy_c   = 1'b1;
                    ctl_addr = user_addr;
                    ctl_rd   = !rw;
                    ctl_cnt  = rw ? int'($urandom_range(4, 1)) : 3;
                end
                if (hs_s) src_idx++;
            end
            ov_prev = out_valid;
            s_valid = (src_idx < src.size()) && (hold_valid || ($urandom_range(1, 0) == 1));
            s_data  = (src_idx < src.size()) ? src[src_idx] : '0;
            m_ready = (rdy_mode == 2) ? 1'($urandom_range(1, 0)) : (rdy_mode != 0);
            #4;
            hs_s     = s_valid && s_ready;
            busy_pre = busy;
        end
    end

    // Request and completion monitor.
    initial begin : mon_req
        req_t r;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst && in_valid) begin
                n_issue++;
                chk("iv_spacing", 64'((cyc - last_iv) >= 2), 64'd1);
                chk("iv_while_busy", 64'(busy_pre), 64'd0);
                last_iv = cyc;
                chk("req_expected", 64'(exp_req.size() != 0), 64'd1);
                if (exp_req.size() != 0) begin
                    r = exp_req.pop_front();
                    chk("req_addr", 64'(user_addr), 64'(r.addr));
                    chk("req_rw", 64'(rw), 64'(r.rw));
                    if (r.rw) chk("req_data", 64'(data_in), 64'(r.data));
                end
            end
            if (!rst && done) begin
                last_done = cyc;
                chk("done_expected", 64'(exp_done.size() != 0), 64'd1);
                chk("active_at_done", 64'(active), 64'd0);
                if (exp_done.size() != 0) chk("done_err", 64'(err), 64'(exp_done.pop_front()));
            end
        end
    end

    // Read-data monitor: a pop happens at the coming edge when m_valid && m_ready.
    initial begin : mon_rd
        forever begin
            @(negedge clk);
            #4;
            if (!rst && m_valid && m_ready) begin
                chk("rd_expected", 64'(exp_rd.size() != 0), 64'd1);
                if (exp_rd.size() != 0) chk("m_data", 64'(m_data), 64'(exp_rd.pop_front()));
            end
        end
    end

    task automatic clear_model();
        exp_req.delete();
        exp_rd.delete();
        exp_done.delete();
        src.delete();
        src_idx = 0;
        last_iv = -100;
    endtask

    task automatic pulse_start(input bit d, input logic [ADDR_W-1:0] b, input int len);
        @(negedge clk);
        dir       = d;
        base_addr = b;
        length    = LEN_W'(len);
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Reference model: word i goes to (base + i) mod 2^ADDR_W; reads return 0xD0 + addr.
    task automatic run_xfer(input bit d, input logic [ADDR_W-1:0] b, input int len,
                            input bit hold, input int rmode, input int dbase);
        req_t r;
        src.delete();
        src_idx    = 0;
        hold_valid = hold;
        rdy_mode   = rmode;
        for (int i = 0; i < len; i++) begin
            r.addr = ADDR_W'(32'(b) + 32'(i));
            r.rw   = d;
            r.data = '0;
            if (d) begin
                r.data = (dbase < 0) ? DATA_W'($urandom) : DATA_W'(dbase + i);
                src.push_back(r.data);
            end else begin
                exp_rd.push_back(32'h0000_00D0 + 32'(r.addr));
            end
            exp_req.push_back(r);
        end
        exp_done.push_back(1'b0);
        pulse_start(d, b, len);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_model();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (exp_done.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_within_budget", 64'(exp_done.size()), 64'd0);
        chk("reqs_all_issued", 64'(exp_req.size()), 64'd0);
        chk("rd_all_delivered", 64'(exp_rd.size()), 64'd0);
        if (exp_done.size() != 0) do_reset();
    endtask

    task automatic wait_issues(input int target, input int budget);
        int n;
        n = 0;
        while (n_issue < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("issue_within_budget", 64'(n_issue >= target), 64'd1);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not complete, got %0d checks", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n0;
        bit d;
        logic [ADDR_W-1:0] b;
        int len;

        rst       = 1'b1;
        start     = 1'b0;
        dir       = 1'b0;
        base_addr = '0;
        length    = '0;
        repeat (3) @(negedge clk);
        chk("rst_active", 64'(active), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_in_valid", 64'(in_valid), 64'd0);
        chk("rst_rw", 64'(rw), 64'd0);
        chk("rst_user_addr", 64'(user_addr), 64'd0);
        chk("rst_data_in", 64'(data_in), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed write of three words.
        run_xfer(1'b1, 23'h000010, 3, 1'b1, 1, 32'hA0);
        wait_done(200);

        // Read of four words with the sink stalled: FIFO fills, completion waits.
        n0 = n_issue;
        run_xfer(1'b0, 23'h000200, 4, 1'b1, 0, -1);
        repeat (40) @(negedge clk);
        chk("rd4_issued", 64'(n_issue - n0), 64'(FIFO_DEPTH));
        chk("rd4_not_done", 64'(exp_done.size()), 64'd1);
        chk("rd4_m_valid", 64'(m_valid), 64'd1);
        rdy_mode = 1;
        wait_done(200);

        // Read longer than the FIFO: issue stalls at FIFO_DEPTH words.
        n0 = n_issue;
        run_xfer(1'b0, 23'h000300, 6, 1'b1, 0, -1);
        repeat (60) @(negedge clk);
        chk("rd6_stalled", 64'(n_issue - n0), 64'(FIFO_DEPTH));
        rdy_mode = 1;
        wait_done(300);

        // Address wrap.
        run_xfer(1'b1, 23'h7FFFFF, 2, 1'b1, 1, -1);
        wait_done(200);

        // Empty transfer: done two cycles after start, no requests.
        n0 = n_issue;
        exp_done.push_back(1'b0);
        @(negedge clk);
        dir       = 1'b1;
        base_addr = 23'h000040;
        length    = '0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("len0_done_early", 64'(done), 64'd0);
        @(negedge clk);
        chk("len0_done", 64'(done), 64'd1);
        chk("len0_err", 64'(err), 64'd0);
        repeat (3) @(negedge clk);
        chk("len0_no_req", 64'(n_issue - n0), 64'd0);

        // A start while active is ignored.
        n0 = n_issue;
        run_xfer(1'b1, 23'h000080, 4, 1'b1, 1, -1);
        repeat (2) @(negedge clk);
        pulse_start(1'b0, 23'h000123, 5);
        wait_done(200);
        repeat (10) @(negedge clk);
        chk("start_while_active_ignored", 64'(n_issue - n0), 64'd4);

        // Controller busy holds off issue.
        n0 = n_issue;
        busy_force = 1'b1;
        run_xfer(1'b1, 23'h000100, 2, 1'b1, 1, -1);
        repeat (10) @(negedge clk);
        chk("busy_no_req", 64'(n_issue - n0), 64'd0);
        busy_force = 1'b0;
        wait_done(200);

        // Reset in the middle of a read.
        n0 = n_issue;
        run_xfer(1'b0, 23'h000400, 4, 1'b1, 0, -1);
        wait_issues(n0 + 2, 100);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_active", 64'(active), 64'd0);
        chk("rstmid_in_valid", 64'(in_valid), 64'd0);
        chk("rstmid_m_valid", 64'(m_valid), 64'd0);
        chk("rstmid_user_addr", 64'(user_addr), 64'd0);
        chk("rstmid_m_data", 64'(m_data), 64'd0);
        chk("rstmid_done", 64'(done), 64'd0);
        clear_model();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_xfer(1'b0, 23'h000500, 3, 1'b1, 1, -1);
        wait_done(200);

`ifdef SDRAM_DMA_TIMEOUT_EN
        // Read data never returns: abort with err after the timeout.
        begin
            req_t r;
            drop_reads = 1'b1;
            rdy_mode   = 1;
            r.addr = 23'h000600;
            r.rw   = 1'b0;
            r.data = '0;
            exp_req.push_back(r);
            exp_done.push_back(1'b1);
            pulse_start(1'b0, 23'h000600, 3);
            wait_done(400);
            chk("timeout_latency", 64'(last_done - last_iv), 64'd256);
            drop_reads = 1'b0;
            repeat (5) @(negedge clk);
        end
`endif

        // Randomized transfers.
        for (int t = 0; t < 12; t++) begin
            d   = 1'($urandom_range(1, 0));
            b   = ($urandom_range(3, 0) == 0) ? 23'h7FFFFC : ADDR_W'($urandom);
            len = int'($urandom_range(8, 1));
            run_xfer(d, b, len, 1'($urandom_range(1, 0)), 2, -1);
            wait_done(3000);
        end

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
